rgb2y_converter: RTL and testbench

RGB2Y_CONVERTER -- requirements
Module: rgb2y_converter

---
 rtl/rgb2y_converter.sv | 149 ++++++++++++++
 tb/tb_rgb2y_converter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rgb2y_converter.sv
// -----------------------------------------------------------------------------
// rgb2y_converter
//   Converts an RGB pixel stream to 8-bit luma with a fixed 3-cycle pipeline:
//     Y = clamp((COEF_R*R + COEF_G*G + COEF_B*B + 128) >> 8, 0, 255)
//   The valid and sync strobes are delayed alongside the data. The output
//   side also counts frames (rising edges of vs_o) and the valid pixels
//   in the last completed frame.
//
// Ports
//   rx_clk         : pixel clock, all logic on its rising edge
//   rst_n          : asynchronous active-low reset
//   red_i/green_i/blue_i : 8-bit colour components
//   dv_i/hs_i/vs_i : data valid / hsync / vsync, aligned with the colour inputs
//   y_o            : 8-bit luma, forced to 0 when dv_o = 0
//   dv_o/hs_o/vs_o : strobes delayed by 3 cycles to align with y_o
//   frame_cnt_o    : frames seen at the output side (wraps)
//   frame_pixels_o : valid pixels in the last completed frame
// -----------------------------------------------------------------------------
module rgb2y_converter #(
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [7:0]  red_i,
  input  logic [7:0]  green_i,
  input  logic [7:0]  blue_i,
  input  logic        dv_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [7:0]  y_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic [15:0] frame_cnt_o,
  output logic [23:0] frame_pixels_o
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  // Coefficients zero-extended to the product width so every multiply is
  // carried out at full 16-bit precision.
  localparam logic [PROD_W-1:0] C_R = {{(PROD_W-COEF_W){1'b0}}, COEF_R[COEF_W-1:0]};
  localparam logic [PROD_W-1:0] C_G = {{(PROD_W-COEF_W){1'b0}}, COEF_G[COEF_W-1:0]};
  localparam logic [PROD_W-1:0] C_B = {{(PROD_W-COEF_W){1'b0}}, COEF_B[COEF_W-1:0]};

  localparam logic [SUM_W-1:0] ROUND_HALF = SUM_W'(128);

  // Keep the integer part of sum/256; anything above 255 clamps instead of
  // wrapping (only reachable when the coefficients sum past 256).
  function automatic logic [DATA_W-1:0] sat_y(input logic [SUM_W-1:0] sum);
    logic [DATA_W-1:0] res;
    if (|sum[SUM_W-1:PROD_W]) res = {DATA_W{1'b1}};
    else                      res = sum[PROD_W-1:DATA_W];
    return res;
  endfunction

  logic [PROD_W-1:0] w_r_ext, w_g_ext, w_b_ext;
  assign w_r_ext = {{(PROD_W-DATA_W){1'b0}}, red_i};
  assign w_g_ext = {{(PROD_W-DATA_W){1'b0}}, green_i};
  assign w_b_ext = {{(PROD_W-DATA_W){1'b0}}, blue_i};

  logic [PROD_W-1:0] r_prod_r_p0, r_prod_g_p0, r_prod_b_p0;
  logic [SUM_W-1:0]  r_sum_p1;
  logic [DATA_W-1:0] r_y_p2;
  // {dv, hs, vs} travelling alongside the data
  logic [2:0]        r_sync_p0, r_sync_p1, r_sync_p2;

  logic              r_vs_prev;
  logic [15:0]       r_frame_cnt;
  logic [23:0]       r_pix_cnt;
  logic [23:0]       r_frame_pixels;
  logic              w_frame_start;

  // ---- Stage 1: products ----
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_r_p0 <= '0;
      r_prod_g_p0 <= '0;
      r_prod_b_p0 <= '0;
      r_sync_p0   <= '0;
    end else begin
      r_prod_r_p0 <= w_r_ext * C_R;
      r_prod_g_p0 <= w_g_ext * C_G;
      r_prod_b_p0 <= w_b_ext * C_B;
      r_sync_p0   <= {dv_i, hs_i, vs_i};
    end
  end

  // ---- Stage 2: rounded sum ----
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1  <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sum_p1  <= {2'b00, r_prod_r_p0} + {2'b00, r_prod_g_p0}
                 + {2'b00, r_prod_b_p0} + ROUND_HALF;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- Stage 3: shift, saturate, blank invalid pixels ----
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_p2    <= '0;
      r_sync_p2 <= '0;
    end else begin
      r_y_p2    <= r_sync_p1[2] ? sat_y(r_sum_p1) : '0;
      r_sync_p2 <= r_sync_p1;
    end
  end

  assign y_o  = r_y_p2;
  assign dv_o = r_sync_p2[2];
  assign hs_o = r_sync_p2[1];
  assign vs_o = r_sync_p2[0];

  // ---- Output-side frame statistics ----
  // r_vs_prev resets to 0, so a vs_o already high right after reset still
  // counts as a frame start; a wide vs_o pulse counts only once.
  assign w_frame_start = vs_o & ~r_vs_prev;

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev      <= 1'b0;
      r_frame_cnt    <= '0;
      r_pix_cnt      <= '0;
      r_frame_pixels <= '0;
    end else begin
      r_vs_prev <= vs_o;
      if (w_frame_start) begin
        r_frame_cnt    <= r_frame_cnt + 16'd1;
        r_frame_pixels <= r_pix_cnt;
        // The pixel coinciding with the frame start belongs to the new frame.
        r_pix_cnt      <= dv_o ? 24'd1 : 24'd0;
      end else if (dv_o && (r_pix_cnt != 24'hFFFFFF)) begin
        r_pix_cnt      <= r_pix_cnt + 24'd1;
      end
    end
  end

  assign frame_cnt_o    = r_frame_cnt;
  assign frame_pixels_o = r_frame_pixels;

endmodule

// File: tb/tb_rgb2y_converter.sv
module tb_rgb2y_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  red_i = '0, green_i = '0, blue_i = '0;
  logic        dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;

  logic [7:0]  y_o, y_s;
  logic        dv_o, hs_o, vs_o, dv_s, hs_s, vs_s;
  logic [15:0] frame_cnt_o, frame_cnt_s;
  logic [23:0] frame_pixels_o, frame_pixels_s;

  always #5 clk = ~clk;

  rgb2y_converter dut (
    .rx_clk(clk), .rst_n(rst_n),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_cnt_o(frame_cnt_o), .frame_pixels_o(frame_pixels_o)
  );

  // Second instance with oversized coefficients to exercise saturation.
  rgb2y_converter #(.COEF_R(255), .COEF_G(255), .COEF_B(255)) dut_sat (
    .rx_clk(clk), .rst_n(rst_n),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_o(y_s), .dv_o(dv_s), .hs_o(hs_s), .vs_o(vs_s),
    .frame_cnt_o(frame_cnt_s), .frame_pixels_o(frame_pixels_s)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       dv, hs, vs;
    logic [7:0] exp_y;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       dv, hs, vs;
    logic [7:0] ysat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] model_y(input int unsigned r, g, b, cr, cg, cb);
    int unsigned s;
    s = (cr * r + cg * g + cb * b + 128) >> 8;
    return (s > 255) ? 8'd255 : s[7:0];
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one pixel, queue its expected output, clock once and compare the
  // output emerging now against the oldest queued expectation.
  task automatic step(input logic [7:0] r, g, b, input logic dv, hs, vs,
                      input logic [7:0] exp_y);
    exp_t e, got;
    @(negedge clk);
    red_i = r; green_i = g; blue_i = b; dv_i = dv; hs_i = hs; vs_i = vs;
    e.y = dv ? exp_y : 8'd0;
    e.dv = dv; e.hs = hs; e.vs = vs;
    e.ysat = dv ? model_y(r, g, b, 255, 255, 255) : 8'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    checks++;
    if ({y_o, dv_o, hs_o, vs_o, y_s} !== {got.y, got.dv, got.hs, got.vs, got.ysat}) begin
      errors++;
      $display("FAIL pix actual y=%0d dv=%b hs=%b vs=%b ysat=%0d required y=%0d dv=%b hs=%b vs=%b ysat=%0d",
               y_o, dv_o, hs_o, vs_o, y_s, got.y, got.dv, got.hs, got.vs, got.ysat);
    end
  endtask

  task automatic step_model(input logic [7:0] r, g, b, input logic dv, hs, vs);
    step(r, g, b, dv, hs, vs, model_y(r, g, b, 77, 150, 29));
  endtask

  // Pipeline is empty after reset: the first two outputs are all-zero.
  task automatic prefill();
    exp_t z;
    z.y = 0; z.dv = 0; z.hs = 0; z.vs = 0; z.ysat = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    red_i = 0; green_i = 0; blue_i = 0; dv_i = 0; hs_i = 0; vs_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prefill();
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{r:255, g:255, b:255, dv:1, hs:0, vs:0, exp_y:255};
    vecs[1]  = '{r:255, g:0,   b:0,   dv:1, hs:0, vs:0, exp_y:77};
    vecs[2]  = '{r:0,   g:100, b:0,   dv:1, hs:0, vs:0, exp_y:59};
    vecs[3]  = '{r:0,   g:0,   b:255, dv:1, hs:0, vs:0, exp_y:29};
    vecs[4]  = '{r:128, g:128, b:128, dv:0, hs:0, vs:0, exp_y:0};
    vecs[5]  = '{r:128, g:128, b:128, dv:0, hs:1, vs:0, exp_y:0};
    vecs[6]  = '{r:0,   g:0,   b:0,   dv:0, hs:0, vs:1, exp_y:0};
    vecs[7]  = '{r:0,   g:0,   b:0,   dv:1, hs:0, vs:0, exp_y:0};
    vecs[8]  = '{r:100, g:50,  b:25,  dv:1, hs:0, vs:0, exp_y:62};
    vecs[9]  = '{r:10,  g:20,  b:30,  dv:1, hs:0, vs:0, exp_y:18};
    vecs[10] = '{r:200, g:100, b:50,  dv:1, hs:0, vs:0, exp_y:124};
    vecs[11] = '{r:1,   g:1,   b:1,   dv:1, hs:0, vs:0, exp_y:1};
    vecs[12] = '{r:255, g:255, b:0,   dv:1, hs:1, vs:0, exp_y:226};
    vecs[13] = '{r:0,   g:255, b:255, dv:1, hs:0, vs:0, exp_y:178};
    vecs[14] = '{r:0,   g:0,   b:0,   dv:0, hs:0, vs:0, exp_y:0};
    vecs[15] = '{r:0,   g:0,   b:0,   dv:0, hs:0, vs:0, exp_y:0};

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_y",    {24'd0, y_o}, 0);
    check_val("rst_sync", {29'd0, dv_o, hs_o, vs_o}, 0);
    check_val("rst_fcnt", {16'd0, frame_cnt_o}, 0);
    check_val("rst_fpix", {8'd0, frame_pixels_o}, 0);
    rst_n = 1'b1;
    prefill();

    // Table of single pixels, back-to-back
    for (int i = 0; i < 16; i++)
      step(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].dv, vecs[i].hs, vecs[i].vs, vecs[i].exp_y);

    // Random pixels with random strobes
    for (int i = 0; i < 40; i++)
      step_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset mid-line with the pipeline full of valid pixels
    for (int i = 0; i < 4; i++)
      step_model(8'(50 + i * 40), 8'(200 - i * 30), 8'(i * 60), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_y",    {24'd0, y_o}, 0);
    check_val("async_rst_sync", {29'd0, dv_o, hs_o, vs_o}, 0);
    check_val("async_rst_fcnt", {16'd0, frame_cnt_o}, 0);
    check_val("async_rst_fpix", {8'd0, frame_pixels_o}, 0);
    dv_i = 0; hs_i = 0; vs_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
    prefill();
    step_model(8'd30, 8'd60, 8'd90, 1'b1, 1'b0, 1'b0);
    step_model(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Frame statistics: 5 pixels before the first vs, then a 640-pixel frame
    do_reset();
    for (int i = 0; i < 5; i++)
      step_model(8'($urandom_range(0, 255)), 8'd7, 8'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_val("frame1_cnt", {16'd0, frame_cnt_o}, 1);
    check_val("frame1_pix", {8'd0, frame_pixels_o}, 5);
    for (int i = 0; i < 640; i++)
      step_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'b1, 1'(i % 64 == 0), 1'b0);
    for (int i = 0; i < 4; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_val("frame2_cnt", {16'd0, frame_cnt_o}, 2);
    check_val("frame2_pix", {8'd0, frame_pixels_o}, 640);

    // Frame counter wrap from 0xFFFF
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    #1;
    check_val("wrap_preload", {16'd0, frame_cnt_o}, 32'hFFFF);
    for (int i = 0; i < 2; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step_model(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_val("wrap_cnt", {16'd0, frame_cnt_o}, 0);
    check_val("wrap_pix", {8'd0, frame_pixels_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
